vertex_feeder: RTL and testbench

VERTEX_FEEDER -- requirements
Module: vertex_feeder

---
 rtl/vertex_feeder.sv | 207 ++++++++++++++++++++
 tb/tb_vertex_feeder.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vertex_feeder.sv
// vertex_feeder: front end for an external fixed-latency 4x4 fp16 matrix-vector shader.
//
// A 16-word matrix is loaded row-major into a register bank that drives shd_a. Vertices
// are then streamed through the shader one per cycle. Each accepted vertex is tagged in a
// SHADER_LAT-deep valid shift register, and the matching shd_out is captured into a result
// FIFO exactly SHADER_LAT cycles after the accept. Vertices are only accepted while the
// FIFO has a free slot for every vertex already in flight. A result can therefore never
// overflow, and results leave in accept order.
//
// Parameters
//   SHADER_LAT  shader latency in cycles (1..15)
//   FIFO_DEPTH  result FIFO entries (power of two, >= SHADER_LAT)
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   load_start             pulse: request a new matrix load (honoured in IDLE and RUN)
//   mat_valid/ready/data   16-bit matrix word stream, element 0 first
//   vin_valid/ready/data   64-bit vertex {w,z,y,x}, x in [15:0]
//   shd_a, shd_b           matrix and vertex presented to the shader
//   shd_out                shader result (4 fp16)
//   vout_valid/ready/data  transformed vertex output (FIFO head)
//   busy                   loading/draining, or results still in flight
//
// Build option
//   VFEED_IDENT_RST_EN  when defined, reset loads the fp16 identity matrix and enters RUN,
//                       so vertices pass through unchanged without a load. Otherwise reset
//                       clears the matrix and enters IDLE.

module vertex_feeder #(
    parameter int unsigned SHADER_LAT = 6,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_start,
    input  logic         mat_valid,
    input  logic [15:0]  mat_data,
    output logic         mat_ready,
    input  logic         vin_valid,
    input  logic [63:0]  vin_data,
    output logic         vin_ready,
    output logic [255:0] shd_a,
    output logic [63:0]  shd_b,
    input  logic [63:0]  shd_out,
    output logic         vout_valid,
    output logic [63:0]  vout_data,
    input  logic         vout_ready,
    output logic         busy
);

    // ------------------------------------------------------------------
    // Local parameters
    // ------------------------------------------------------------------
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    // Wide enough to hold fifo count + in-flight count (each <= FIFO_DEPTH).
    localparam int unsigned CNT_W = PTR_W + 2;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

`ifdef VFEED_IDENT_RST_EN
    // Diagonal elements 0, 5, 10, 15 hold 1.0; element 15 sits in the top bits.
    localparam logic [255:0] RST_MAT   = {16'h3C00, 64'h0, 16'h3C00, 64'h0,
                                          16'h3C00, 64'h0, 16'h3C00};
    localparam logic [1:0]   RST_STATE = ST_RUN;
`else
    localparam logic [255:0] RST_MAT   = '0;
    localparam logic [1:0]   RST_STATE = ST_IDLE;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q, state_d;
    logic [3:0]            word_cnt_q;
    logic [255:0]          mat_q;
    logic [63:0]           shd_b_q;
    logic [SHADER_LAT-1:0] vld_sr_q, vld_sr_d;

    logic [63:0]           fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      fifo_cnt_q;

    // ------------------------------------------------------------------
    // Handshakes and status
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] inflight;
    logic             mat_accept;
    logic             vin_accept;
    logic             push;
    logic             pop;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < SHADER_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_sr_q[i]);
        end
    end

    assign mat_ready  = (state_q == ST_LOAD);
    assign mat_accept = mat_valid && mat_ready;

    // Credit check ignores a same-cycle pop. load_start wins over a vertex in RUN.
    assign vin_ready  = (state_q == ST_RUN) && !load_start &&
                        ((fifo_cnt_q + inflight) < DEPTH_C);
    assign vin_accept = vin_valid && vin_ready;

    // Oldest shift-register tap marks the cycle the shader result is valid.
    assign push       = vld_sr_q[SHADER_LAT-1];
    assign vout_valid = (fifo_cnt_q != '0);
    assign pop        = vout_valid && vout_ready;
    assign vout_data  = fifo_mem[rd_ptr_q];

    assign busy  = (state_q == ST_LOAD) || (state_q == ST_DRAIN) || (inflight != '0);
    assign shd_a = mat_q;
    assign shd_b = shd_b_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (load_start) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (mat_accept && (word_cnt_q == 4'd15)) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (load_start) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Wait only for the shader pipe; results already in the FIFO stay there.
                if (inflight == '0) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vld_sr_d    = '0;
        vld_sr_d[0] = vin_accept;
        for (int i = 1; i < SHADER_LAT; i++) begin
            vld_sr_d[i] = vld_sr_q[i-1];
        end
    end

    // ------------------------------------------------------------------
    // Control and matrix registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RST_STATE;
            word_cnt_q <= '0;
            mat_q      <= RST_MAT;
            shd_b_q    <= '0;
            vld_sr_q   <= '0;
        end else begin
            state_q  <= state_d;
            vld_sr_q <= vld_sr_d;
            if (mat_accept) begin
                mat_q[{word_cnt_q, 4'b0000} +: 16] <= mat_data;
                word_cnt_q <= word_cnt_q + 4'd1;  // wraps to 0 after the 16th word
            end
            if (vin_accept) begin
                shd_b_q <= vin_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    // Data storage needs no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= shd_out;
        end
    end

endmodule

// File: tb/tb_vertex_feeder.sv
// Bench for vertex_feeder: a fp16 shader model with SHADER_LAT latency, a matrix/vertex
// scoreboard checked every cycle, and directed scenarios with literal expectations.

module tb_vertex_feeder;

    localparam int L = 6;
    localparam int D = 8;

    logic         clk;
    logic         rst;
    logic         load_start;
    logic         mat_valid;
    logic [15:0]  mat_data;
    logic         mat_ready;
    logic         vin_valid;
    logic [63:0]  vin_data;
    logic         vin_ready;
    logic [255:0] shd_a;
    logic [63:0]  shd_b;
    logic [63:0]  shd_out;
    logic         vout_valid;
    logic [63:0]  vout_data;
    logic         vout_ready;
    logic         busy;

    int checks = 0;
    int errors = 0;

    vertex_feeder #(
        .SHADER_LAT (L),
        .FIFO_DEPTH (D)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .mat_valid  (mat_valid),
        .mat_data   (mat_data),
        .mat_ready  (mat_ready),
        .vin_valid  (vin_valid),
        .vin_data   (vin_data),
        .vin_ready  (vin_ready),
        .shd_a      (shd_a),
        .shd_b      (shd_b),
        .shd_out    (shd_out),
        .vout_valid (vout_valid),
        .vout_data  (vout_data),
        .vout_ready (vout_ready),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- fp16 helpers (normal numbers only) ----------------
    function automatic real h2r(input logic [15:0] h);
        real r;
        int  e;
        if (h[14:10] == 5'd0) return 0.0;
        r = 1.0 + real'(h[9:0]) / 1024.0;
        e = int'(h[14:10]);
        while (e > 15) begin r = r * 2.0; e--; end
        while (e < 15) begin r = r / 2.0; e++; end
        return h[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2h(input real x);
        real a;
        int  e;
        int  m;
        logic s;
        if (x == 0.0) return 16'h0000;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 15;
        while (a >= 2.0 && e < 30) begin a = a / 2.0; e++; end
        while (a < 1.0 && e > 1) begin a = a * 2.0; e--; end
        m = $rtoi((a - 1.0) * 1024.0 + 0.5);
        if (m == 1024) begin m = 0; e++; end
        return {s, e[4:0], m[9:0]};
    endfunction

    function automatic logic [63:0] matvec(input logic [255:0] a, input logic [63:0] v);
        logic [63:0] r;
        real acc;
        for (int i = 0; i < 4; i++) begin
            acc = 0.0;
            for (int j = 0; j < 4; j++) begin
                acc = acc + h2r(a[16*(4*i+j) +: 16]) * h2r(v[16*j +: 16]);
            end
            r[16*i +: 16] = r2h(acc);
        end
        return r;
    endfunction

    function automatic logic [255:0] diag(input logic [15:0] d);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[16*(5*i) +: 16] = d;
        return r;
    endfunction

    // Small integers 1..8 in fp16.
    function automatic logic [15:0] lut(input int i);
        case (i % 8)
            0: return 16'h3C00;
            1: return 16'h4000;
            2: return 16'h4200;
            3: return 16'h4400;
            4: return 16'h4500;
            5: return 16'h4600;
            6: return 16'h4700;
            default: return 16'h4800;
        endcase
    endfunction

    function automatic logic [63:0] vtx(input int i);
        return {lut(i + 3), lut(i + 2), lut(i + 1), lut(i)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- shader model: result valid SHADER_LAT edges after shd_b ----------------
    logic [63:0] shd_pipe [L-1];
    always @(posedge clk) begin
        shd_pipe[0] <= matvec(shd_a, shd_b);
        for (int i = 1; i < L - 1; i++) shd_pipe[i] <= shd_pipe[i-1];
    end
    assign shd_out = shd_pipe[L-2];

    // ---------------- scoreboard ----------------
    logic [255:0] model_mat;
    int           mword;
    logic [63:0]  exp_q [$];

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            mword = 0;
`ifdef VFEED_IDENT_RST_EN
            model_mat = diag(16'h3C00);
`else
            model_mat = '0;
`endif
        end else begin
            if (exp_q.size() == 0) begin
                check("vout_valid_unexpected", 64'(vout_valid), 64'd0);
            end else if (vout_valid) begin
                check("vout_data", vout_data, exp_q[0]);
                if (vout_ready) void'(exp_q.pop_front());
            end
            if (mat_valid && mat_ready) begin
                model_mat[16*mword +: 16] = mat_data;
                mword = (mword + 1) % 16;
            end
            if (vin_valid && vin_ready) exp_q.push_back(matvec(model_mat, vin_data));
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_matrix(input logic [255:0] m, input int nwords);
        logic ok;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            mat_valid = 1'b1;
            mat_data  = m[16*k +: 16];
            ok = 1'b0;
            for (int t = 0; t < 40 && !ok; t++) begin
                @(negedge clk);
                ok = mat_ready;
                tick();
            end
            check("mat_word_accepted", 64'(ok), 64'd1);
        end
        mat_valid = 1'b0;
    endtask

    task automatic send_vertex(input logic [63:0] v);
        logic ok;
        vin_valid = 1'b1;
        vin_data  = v;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = vin_ready;
            tick();
        end
        vin_valid = 1'b0;
        check("vertex_accepted", 64'(ok), 64'd1);
    endtask

    task automatic wait_vout(input string name, input logic [63:0] exp);
        logic ok;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            ok = vout_valid;
            if (!ok) tick();
        end
        check("vout_seen", 64'(ok), 64'd1);
        if (ok) check(name, vout_data, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int idx;
        int last;
        int pops;
        logic [255:0] rot;

        rst = 1'b1; load_start = 1'b0; mat_valid = 1'b0; mat_data = '0;
        vin_valid = 1'b0; vin_data = '0; vout_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mat_ready", 64'(mat_ready), 64'd0);
        check("rst_vout_valid", 64'(vout_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_shd_b", shd_b, 64'd0);
`ifdef VFEED_IDENT_RST_EN
        check("rst_vin_ready", 64'(vin_ready), 64'd1);
`else
        check("rst_vin_ready", 64'(vin_ready), 64'd0);
`endif
        tick();

        // Identity after reset (macro) / no vertex accepted without a load
`ifdef VFEED_IDENT_RST_EN
        send_vertex(64'h4200_4400_4500_3C00);
        wait_vout("ident_passthru", 64'h4200_4400_4500_3C00);
`else
        vin_valid = 1'b1;
        vin_data  = 64'h4200_4400_4500_3C00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("idle_vin_ready", 64'(vin_ready), 64'd0);
            tick();
        end
        vin_valid = 1'b0;
`endif

        // Diag 2.0 times all-ones, latency SHADER_LAT edges after accept
        load_matrix(diag(16'h4000), 16);
        vin_valid = 1'b1;
        vin_data  = 64'h3C00_3C00_3C00_3C00;
        @(negedge clk);
        check("run_vin_ready", 64'(vin_ready), 64'd1);
        tick();
        vin_valid = 1'b0;
        check("shd_b_capture", shd_b, 64'h3C00_3C00_3C00_3C00);
        for (int k = 1; k <= L; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("latency_valid", 64'(vout_valid), 64'(k == L));
            if (k == 1) check("busy_inflight", 64'(busy), 64'd1);
            if (k == L) check("diag2_result", vout_data, 64'h4000_4000_4000_4000);
        end
        tick();
        check("shd_b_hold", shd_b, 64'h3C00_3C00_3C00_3C00);

        // Back-pressure: exactly D accepts, back to back, then in-order drain
        vout_ready = 1'b0;
        vin_valid  = 1'b1;
        idx = 0;
        last = -1;
        for (int c = 0; c < 30; c++) begin
            vin_data = vtx(idx);
            @(negedge clk);
            if (vin_ready) begin
                idx++;
                last = c;
            end
            tick();
        end
        vin_valid = 1'b0;
        check("fill_count", 64'(idx), 64'(D));
        check("fill_last_cycle", 64'(last), 64'(D - 1));
        @(negedge clk);
        check("full_vin_ready", 64'(vin_ready), 64'd0);
        check("full_vout_valid", 64'(vout_valid), 64'd1);
        tick();
        vout_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (vout_valid) pops++;
            tick();
        end
        check("drain_count", 64'(pops), 64'(D));

        // Reload with 3 in flight: DRAIN until they land, then LOAD
        vin_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            vin_data = vtx(c);
            @(negedge clk);
            check("b2b_accept", 64'(vin_ready), 64'd1);
            tick();
        end
        vin_data   = vtx(3);
        load_start = 1'b1;
        @(negedge clk);
        check("load_prio_vin_ready", 64'(vin_ready), 64'd0);
        tick();
        load_start = 1'b0;
        vin_valid  = 1'b0;
        for (int c = 0; c < L; c++) begin
            @(negedge clk);
            check("drain_mat_ready", 64'(mat_ready), 64'd0);
            check("drain_busy", 64'(busy), 64'd1);
            tick();
        end
        @(negedge clk);
        check("load_after_drain", 64'(mat_ready), 64'd1);
        tick();
        load_matrix(diag(16'h4200), 16);
        send_vertex(vtx(0));
        wait_vout("diag3_result", 64'h4A00_4880_4600_4200);

        // Reset mid-load with results pending, then a fresh full load
        vout_ready = 1'b0;
        send_vertex(vtx(2));
        send_vertex(vtx(3));
        load_matrix({16{16'h4800}}, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midload_rst_mat_ready", 64'(mat_ready), 64'd0);
        check("midload_rst_vout_valid", 64'(vout_valid), 64'd0);
        check("midload_rst_busy", 64'(busy), 64'd0);
        tick();
        vout_ready = 1'b1;
        rot = '0;
        for (int i = 0; i < 4; i++) rot[16*(4*i + (i+1)%4) +: 16] = 16'h3C00;
        load_matrix(rot, 16);
        send_vertex(vtx(1));
        wait_vout("rotate_result", 64'h4000_4500_4400_4200);

        repeat (10) tick();
        @(negedge clk);
        check("final_model_empty", 64'(exp_q.size()), 64'd0);
        check("final_vout_valid", 64'(vout_valid), 64'd0);
        check("final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
